sparsity_mode_ctrl_mc: RTL

Multi-channel successor to the single-stream adaptive sparsity FSM. It accumulates per-channel nonzero/total counts over a window of samples and computes window density in milli-units with a shared sequential divider. It then selects a structured-sparsity mode per channel (DENSE / 2:4 / 1:4 / 1:8) using hysteresis and minimum-hold rules, and supports per-channel manual override. It sits between the activation sparsity monitors and the PE-array mode configuration registers.

---
 rtl/sparsity_pkg.sv | 51 +++++
 rtl/seq_divider_milli.sv | 91 +++++++++
 rtl/sparsity_mode_ctrl_mc.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sparsity_pkg.sv
// Shared definitions for the multi-channel sparsity mode controller.
//
// Contents:
//   MILLI          - fixed-point scale of the density value (1000 = fully dense)
//   mode_e         - structured-sparsity mode encoding driven to the PE array
//   ctrl_state_e   - controller FSM state encoding (visible as state_q in the top)
//   classify       - maps a density to a mode given three thresholds
//   thr_lower      - threshold minus hysteresis, saturating at zero
//   thr_raise      - threshold plus hysteresis, widened so it cannot wrap
package sparsity_pkg;

    localparam int MILLI = 1000;

    typedef enum logic [1:0] {
        MODE_DENSE = 2'd0,
        MODE_2TO4  = 2'd1,
        MODE_1TO4  = 2'd2,
        MODE_1TO8  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_DECIDE = 2'd2
    } ctrl_state_e;

    // Densities and adjusted thresholds are carried on 12 bits: a raised
    // threshold can reach 1023 + 1023.
    function automatic mode_e classify(input logic [11:0] d,
                                       input logic [11:0] t_2to4,
                                       input logic [11:0] t_1to4,
                                       input logic [11:0] t_1to8);
        if (d >= t_2to4) begin
            return MODE_DENSE;
        end else if (d >= t_1to4) begin
            return MODE_2TO4;
        end else if (d >= t_1to8) begin
            return MODE_1TO4;
        end
        return MODE_1TO8;
    endfunction

    function automatic logic [11:0] thr_lower(input logic [9:0] t, input logic [9:0] h);
        return (t > h) ? {2'b00, t - h} : 12'd0;
    endfunction

    function automatic logic [11:0] thr_raise(input logic [9:0] t, input logic [9:0] h);
        return {2'b00, t} + {2'b00, h};
    endfunction

endpackage

// File: rtl/seq_divider_milli.sv
// Sequential restoring divider producing floor(num * 1000 / den).
//
// One quotient bit per cycle over ACC_W+10 cycles after the start edge.
// When den == 0 or num > den the result is clamped to 1000; the full cycle
// count is still spent so the caller sees a fixed latency.
//
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset (aborts a divide)
//   start_i         load operands and begin (ignored while busy)
//   num_i, den_i    numerator / denominator (ACC_W bits)
//   busy_o          divide in progress
//   done_o          one-cycle pulse after the last iteration; quot_o valid
//                   from then until the next start
//   quot_o          density in milli-units, 0..1000
//
// ACC_W must be at least 6 so that the quotient register spans 16 bits.
module seq_divider_milli
    import sparsity_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [ACC_W-1:0] num_i,
    input  logic [ACC_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      quot_o
);

    localparam int DW   = ACC_W + 10;
    localparam int ITER = ACC_W + 10;
    localparam int IW   = $clog2(ITER + 1);

    // quo_q starts as the dividend and shifts quotient bits in from the LSB
    // while dividend bits leave from the MSB into the partial remainder.
    logic [DW-1:0]    quo_q, quo_d;
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] den_q;
    logic [IW-1:0]    iter_q;
    logic             busy_q, done_q, clamp_q;
    logic [ACC_W:0]   trial;

    always_comb begin
        trial = {rem_q, quo_q[DW-1]};
        if (trial >= {1'b0, den_q}) begin
            rem_d = ACC_W'(trial - {1'b0, den_q});
            quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
            rem_d = trial[ACC_W-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                quo_q   <= DW'(num_i) * DW'(MILLI);
                rem_q   <= '0;
                den_q   <= den_i;
                iter_q  <= IW'(ITER);
                busy_q  <= 1'b1;
                clamp_q <= (den_i == '0) || (num_i > den_i);
            end else if (busy_q) begin
                quo_q  <= quo_d;
                rem_q  <= rem_d;
                iter_q <= iter_q - IW'(1);
                if (iter_q == IW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    // Unclamped quotient is at most 1000, so the low 16 bits hold it exactly.
    assign quot_o = clamp_q ? 16'(MILLI) : quo_q[15:0];

endmodule

// File: rtl/sparsity_mode_ctrl_mc.sv
// Multi-channel adaptive structured-sparsity mode controller.
//
// Accumulates per-channel nonzero/total element counts over WINDOW_SIZE
// accepted samples, turns each closed window into a density (milli-units)
// with one shared sequential divider, and picks DENSE / 2:4 / 1:4 / 1:8 per
// channel using hysteresis and a minimum-hold rule. Manual override per
// channel forces the mode directly.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   sample_valid / sample_ready     sample handshake
//   sample_ch                       target channel (>= NUM_CH: accepted, dropped)
//   nonzero_count, total_count      per-sample counts
//   manual_override, manual_mode    per-channel forced mode (ch c at [2c+1:2c])
//   thresh_2to4/1to4/1to8           density boundaries in milli
//   hyst_milli                      hysteresis band in milli
//   min_hold_windows                decided windows required before an automatic change
//   mode_out, mode_change_pulse     current mode per channel, one-cycle change pulses
//   density_valid/_ch/_milli        report of the last completed window
//   change_count                    total mode changes, saturating
//
// Handshake: a sample transfers on a rising edge where sample_valid and
// sample_ready are both high. sample_ready is high only while the FSM is
// IDLE; the producer must hold the sample stable until it transfers.
//
// The FSM state is kept in state_q (ctrl_state_e) for observation.
module sparsity_mode_ctrl_mc
    import sparsity_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WINDOW_SIZE = 8,
    parameter int CNT_W       = 16,
    parameter int ACC_W       = 24,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [CH_W-1:0]     sample_ch,
    input  logic [CNT_W-1:0]    nonzero_count,
    input  logic [CNT_W-1:0]    total_count,
    input  logic [NUM_CH-1:0]   manual_override,
    input  logic [2*NUM_CH-1:0] manual_mode,
    input  logic [9:0]          thresh_2to4,
    input  logic [9:0]          thresh_1to4,
    input  logic [9:0]          thresh_1to8,
    input  logic [9:0]          hyst_milli,
    input  logic [7:0]          min_hold_windows,
    output logic [2*NUM_CH-1:0] mode_out,
    output logic [NUM_CH-1:0]   mode_change_pulse,
    output logic                density_valid,
    output logic [CH_W-1:0]     density_ch,
    output logic [15:0]         density_milli,
    output logic [15:0]         change_count
);

    localparam int WC_W = $clog2(WINDOW_SIZE + 1);
    localparam int AW1  = ACC_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctrl_state_e      state_q;
    logic [ACC_W-1:0] nz_acc_q  [NUM_CH];
    logic [ACC_W-1:0] tot_acc_q [NUM_CH];
    logic [WC_W-1:0]  cnt_q     [NUM_CH];
    mode_e            mode_q    [NUM_CH];
    mode_e            mode_d    [NUM_CH];
    logic [7:0]       hold_q    [NUM_CH];
    logic [7:0]       hold_d    [NUM_CH];
    logic [CH_W-1:0]  dec_ch_q;
    logic [NUM_CH-1:0] pulse_q, chg;
    logic             dv_q;
    logic [CH_W-1:0]  dch_q;
    logic [15:0]      dmilli_q;
    logic [15:0]      cc_q, cc_d;

    // ------------------------------------------------------------------
    // Sample acceptance
    // ------------------------------------------------------------------
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + AW1'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    logic             ch_ok, accept, win_close;
    logic [CH_W-1:0]  idx;
    logic [ACC_W-1:0] nz_sum, tot_sum;
    logic             div_start, div_busy, div_done;
    logic [15:0]      div_quot;

    assign sample_ready = (state_q == ST_IDLE);
    assign ch_ok        = (int'(sample_ch) < NUM_CH);
    // Out-of-range channels still handshake but touch no channel state;
    // idx is forced in range so array reads stay defined.
    assign idx          = ch_ok ? sample_ch : '0;
    assign accept       = sample_valid && sample_ready && ch_ok;
    assign nz_sum       = sat_add(nz_acc_q[idx], nonzero_count);
    assign tot_sum      = sat_add(tot_acc_q[idx], total_count);
    assign win_close    = (cnt_q[idx] == WC_W'(WINDOW_SIZE - 1));
    assign div_start    = accept && win_close && !div_busy;

    seq_divider_milli #(
        .ACC_W (ACC_W)
    ) u_div (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (div_start),
        .num_i   (nz_sum),
        .den_i   (tot_sum),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quot_o  (div_quot)
    );

    // ------------------------------------------------------------------
    // Window decision for the channel that just finished dividing
    // ------------------------------------------------------------------
    mode_e cur_mode, mode_s, mode_h, auto_mode;

    assign cur_mode = mode_q[dec_ch_q];
    // mode_s uses lowered thresholds: moving sparser needs to clear the band.
    // mode_h uses raised thresholds: moving denser needs to clear the band.
    assign mode_s = classify(div_quot[11:0],
                             thr_lower(thresh_2to4, hyst_milli),
                             thr_lower(thresh_1to4, hyst_milli),
                             thr_lower(thresh_1to8, hyst_milli));
    assign mode_h = classify(div_quot[11:0],
                             thr_raise(thresh_2to4, hyst_milli),
                             thr_raise(thresh_1to4, hyst_milli),
                             thr_raise(thresh_1to8, hyst_milli));

    always_comb begin
        auto_mode = cur_mode;
        if (mode_s > cur_mode) begin
            auto_mode = mode_s;
        end else if (mode_h < cur_mode) begin
            auto_mode = mode_h;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel next mode / hold, override taking priority
    // ------------------------------------------------------------------
    logic [15:0] n_chg;
    logic [16:0] cc_sum;

    always_comb begin
        n_chg = '0;
        chg   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_d[c] = mode_q[c];
            hold_d[c] = hold_q[c];
            if (manual_override[c]) begin
                if (mode_e'(manual_mode[2*c +: 2]) != mode_q[c]) begin
                    mode_d[c] = mode_e'(manual_mode[2*c +: 2]);
                    hold_d[c] = '0;
                    chg[c]    = 1'b1;
                end
            end else if ((state_q == ST_DECIDE) && (int'(dec_ch_q) == c)) begin
                // Hold age is compared before it is advanced for this window.
                if ((auto_mode != mode_q[c]) && (hold_q[c] >= min_hold_windows)) begin
                    mode_d[c] = auto_mode;
                    hold_d[c] = '0;
                    chg[c]    = 1'b1;
                end else if (hold_q[c] != 8'hFF) begin
                    hold_d[c] = hold_q[c] + 8'd1;
                end
            end
            if (chg[c]) begin
                n_chg = n_chg + 16'd1;
            end
        end
        cc_sum = {1'b0, cc_q} + {1'b0, n_chg};
        cc_d   = cc_sum[16] ? 16'hFFFF : cc_sum[15:0];
    end

    // ------------------------------------------------------------------
    // Controller FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dec_ch_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                nz_acc_q[c]  <= '0;
                tot_acc_q[c] <= '0;
                cnt_q[c]     <= '0;
                mode_q[c]    <= MODE_DENSE;
                hold_q[c]    <= 8'hFF;
            end
            pulse_q  <= '0;
            dv_q     <= 1'b0;
            dch_q    <= '0;
            dmilli_q <= '0;
            cc_q     <= '0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (win_close) begin
                            // Sums including this sample went to the divider.
                            nz_acc_q[idx]  <= '0;
                            tot_acc_q[idx] <= '0;
                            cnt_q[idx]     <= '0;
                            dec_ch_q       <= idx;
                            state_q        <= ST_DIV;
                        end else begin
                            nz_acc_q[idx]  <= nz_sum;
                            tot_acc_q[idx] <= tot_sum;
                            cnt_q[idx]     <= cnt_q[idx] + WC_W'(1);
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    state_q  <= ST_IDLE;
                    dv_q     <= 1'b1;
                    dch_q    <= dec_ch_q;
                    dmilli_q <= div_quot;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c] <= mode_d[c];
                hold_q[c] <= hold_d[c];
            end
            pulse_q <= chg;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        mode_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_out[2*c +: 2] = mode_q[c];
        end
    end

    assign mode_change_pulse = pulse_q;
    assign density_valid     = dv_q;
    assign density_ch        = dch_q;
    assign density_milli     = dmilli_q;
    assign change_count      = cc_q;

endmodule
